// File: rtl/viterbi_acs_traceback.sv
// viterbi_acs_traceback: hard-decision K=3 rate-1/2 Viterbi decoder (G0=111, G1=101), 4-state ACS with frame traceback
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   i_valid  : i_symbol valid this cycle
//   i_symbol : [1]=G0 parity, [0]=G1 parity
//   o_ready  : symbols accepted (IDLE/ACS); dropped otherwise
//   o_busy   : traceback in progress or result presented (TRACE/DONE)
//   o_data   : decoded word, bit t = t-th decoded bit
//   o_valid  : one-cycle pulse qualifying o_data
module viterbi_acs_traceback #(
  parameter int N_BITS      = 8,
  parameter int SIZE_SYMBOL = 2,
  parameter int PM_WIDTH    = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [SIZE_SYMBOL-1:0] i_symbol,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic [N_BITS-1:0]      o_data,
  output logic                   o_valid
);
  localparam int IW = $clog2(N_BITS);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(N_BITS);
  localparam logic [PM_WIDTH-1:0] MAX = {PM_WIDTH{1'b1}};
  localparam logic [3:0][PM_WIDTH-1:0] PM_INIT = {MAX, MAX, MAX, {PM_WIDTH{1'b0}}};
  typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [3:0][PM_WIDTH-1:0] r_pm;
  logic [3:0][PM_WIDTH-1:0] w_pm_nx;
  logic [N_BITS-1:0][3:0] r_surv;
  logic [N_BITS-1:0] r_data;
  logic [1:0] r_ts;
  logic [3:0] w_dec;
  logic [1:0] w_min, w_lo, w_hi, w_cur;
  logic [IW-1:0] w_wr_idx, w_rd_idx;
  logic w_acc;
  // Hamming distance between the received symbol and the branch label of pred p under input u.
  function automatic logic [1:0] bm(input logic [1:0] sym, input logic u, input logic [1:0] p);
    logic [1:0] e;
    e = {u ^ p[1] ^ p[0], u ^ p[0]} ^ sym;
    return {1'b0, e[1]} + {1'b0, e[0]};
  endfunction
  function automatic logic [PM_WIDTH-1:0] sat(input logic [PM_WIDTH-1:0] pm, input logic [1:0] b);
    logic [PM_WIDTH:0] s;
    s = {1'b0, pm} + {{(PM_WIDTH-1){1'b0}}, b};
    return s[PM_WIDTH] ? MAX : s[PM_WIDTH-1:0];
  endfunction
  // Next state ns={u,s[1]} has predecessors {ns[0],0} and {ns[0],1}; decision bit is the pred's s[0].
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic [1:0] NS = 2'(g);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};
    logic [PM_WIDTH-1:0] w_c0, w_c1;
    assign w_c0 = sat(r_pm[P0], bm(i_symbol, NS[1], P0));
    assign w_c1 = sat(r_pm[P1], bm(i_symbol, NS[1], P1));
    assign w_dec[g] = w_c1 < w_c0;
    assign w_pm_nx[g] = w_dec[g] ? w_c1 : w_c0;
  end
  // Strict compares keep the lower index on ties.
  assign w_lo = (r_pm[1] < r_pm[0]) ? 2'd1 : 2'd0;
  assign w_hi = (r_pm[3] < r_pm[2]) ? 2'd3 : 2'd2;
  assign w_min = (r_pm[w_hi] < r_pm[w_lo]) ? w_hi : w_lo;
  // The first trace cycle starts from the best final state; later cycles follow the walked-back state.
  assign w_cur = (r_cnt == FULL) ? w_min : r_ts;
  assign w_wr_idx = r_cnt[IW-1:0];
  assign w_rd_idx = IW'(r_cnt - 1'b1);
  assign w_acc = i_valid & o_ready;
  assign o_data = r_data;
  always_comb begin
    w_state_nx = r_state;
    o_ready = 1'b0;
    o_busy = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      IDLE, ACS: begin
        o_ready = 1'b1;
        w_state_nx = !(i_valid) ? r_state : (r_cnt == LAST) ? TRACE : ACS;
      end
      TRACE: begin
        o_busy = 1'b1;
        w_state_nx = (r_cnt == 1) ? DONE : TRACE;
      end
      default: begin
        o_busy = 1'b1;
        o_valid = 1'b1;
        w_state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_pm <= PM_INIT;
      r_surv <= '0;
      r_data <= '0;
      r_ts <= '0;
    end else if (w_acc) begin
      r_pm <= w_pm_nx;
      r_surv[w_wr_idx] <= w_dec;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == TRACE) begin
      r_data[w_rd_idx] <= w_cur[1];
      r_ts <= {w_cur[0], r_surv[w_rd_idx][w_cur]};
      r_cnt <= r_cnt - 1'b1;
    end else if (r_state == DONE) begin
      r_pm <= PM_INIT;
      r_data <= '0;
    end
  end
endmodule

// File: tb/tb_viterbi_acs_traceback.sv
// tb_viterbi_acs_traceback: directed scoreboard bench for the K=3 rate-1/2 Viterbi decoder
module tb_viterbi_acs_traceback;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic [1:0] i_symbol = 2'b00;
  logic o_ready, o_busy, o_valid;
  logic [N-1:0] o_data;
  int checks = 0;
  int failures = 0;
  int vcount = 0;
  logic [N-1:0] sb[$];
  viterbi_acs_traceback #(.N_BITS(N), .SIZE_SYMBOL(2), .PM_WIDTH(5)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .i_symbol(i_symbol),
    .o_ready(o_ready),
    .o_busy(o_busy),
    .o_data(o_data),
    .o_valid(o_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      vcount++;
      if (sb.size() == 0) chk("unexpected_valid", 32'(o_valid), 32'd0);
      else chk("data", 32'(o_data), 32'(sb.pop_front()));
    end
  end
  // Drives one frame (first symbol in syms[15:14]); optionally stops after n symbols and
  // optionally presents junk symbols while the decoder is tracing back.
  task automatic frame(input string tag, input logic [15:0] syms, input logic [N-1:0] exp,
                       input int gap, input bit junk, input int n);
    int lat;
    if (n == N) sb.push_back(exp);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_symbol = syms[15-2*i -: 2];
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      if (i < n - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    if (n != N) return;
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
    lat = 0;
    while (!o_valid && lat < 40) begin
      i_valid = junk && lat < 3;
      i_symbol = 2'b11;
      @(posedge clk);
      #1;
      lat++;
    end
    i_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(N));
    @(posedge clk);
    #1;
    chk({tag, "_idle_data"}, 32'(o_data), 32'd0);
    chk({tag, "_idle_ready"}, 32'(o_ready), 32'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    frame("zeros", 16'h0000, 8'h00, 0, 1'b0, N);
    frame("ones", 16'hDAAA, 8'hFF, 0, 1'b0, N);
    frame("one_lsb", 16'hEC00, 8'h01, 0, 1'b0, N);
    frame("corrected", 16'hDEAA, 8'hFF, 0, 1'b0, N);
    frame("gaps", 16'hDAAA, 8'hFF, 3, 1'b1, N);
    frame("after_junk", 16'h0000, 8'h00, 0, 1'b0, N);
    frame("aborted", 16'hDAAA, 8'hFF, 0, 1'b0, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    frame("post_rst", 16'h0000, 8'h00, 0, 1'b0, N);
    repeat (5) @(posedge clk);
    #1;
    chk("valid_count", 32'(vcount), 32'd7);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
